// File: rtl/id_ex_ctrl.sv
// rtl/id_ex_ctrl.sv - ID/EX pipeline register with instruction decode and condition gating
// Decodes the IF/ID instruction and registers EX controls, or a bubble when the instruction must not execute.
module id_ex_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        freeze,
    input  logic        flush,
    input  logic [3:0]  status,
    output logic [3:0]  exe_command,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        branch,
    output logic        s_bit,
    output logic        imm,
    output logic        valid_out,
    output logic [3:0]  dest,
    output logic [3:0]  src1,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm_24,
    output logic        two_src
);

    logic [3:0] w_cond;
    logic [1:0] w_mode;
    logic [3:0] w_opcode;
    logic       w_i;
    logic       w_s;
    logic       w_n, w_z, w_c, w_v;

    assign w_cond   = instr[31:28];
    assign w_mode   = instr[27:26];
    assign w_i      = instr[25];
    assign w_opcode = instr[24:21];
    assign w_s      = instr[20];
    assign {w_n, w_z, w_c, w_v} = status;

    logic [3:0] w_exe;
    logic       w_wb, w_mr, w_mw, w_br, w_sb;
    logic       w_store;
    logic       w_cond_pass;
    logic       w_load_ctrl;

    always_comb begin
        w_exe = 4'b0000;
        w_wb  = 1'b0;
        w_mr  = 1'b0;
        w_mw  = 1'b0;
        w_br  = 1'b0;
        w_sb  = 1'b0;
        case (w_mode)
            2'b00: begin
                case (w_opcode)
                    4'b1101: begin w_exe = 4'b0001; w_wb = 1'b1; w_sb = w_s; end
                    4'b1111: begin w_exe = 4'b1001; w_wb = 1'b1; w_sb = w_s; end
                    4'b0100: begin w_exe = 4'b0010; w_wb = 1'b1; w_sb = w_s; end
                    4'b0101: begin w_exe = 4'b0011; w_wb = 1'b1; w_sb = w_s; end
                    4'b0010: begin w_exe = 4'b0100; w_wb = 1'b1; w_sb = w_s; end
                    4'b0110: begin w_exe = 4'b0101; w_wb = 1'b1; w_sb = w_s; end
                    4'b0000: begin w_exe = 4'b0110; w_wb = 1'b1; w_sb = w_s; end
                    4'b1100: begin w_exe = 4'b0111; w_wb = 1'b1; w_sb = w_s; end
                    4'b0001: begin w_exe = 4'b1000; w_wb = 1'b1; w_sb = w_s; end
                    // Compare/test only update flags, so S is forced on.
                    4'b1010: begin w_exe = 4'b0100; w_sb = 1'b1; end
                    4'b1000: begin w_exe = 4'b0110; w_sb = 1'b1; end
                    default: ;
                endcase
            end
            2'b01: begin
                w_exe = 4'b0010;
                if (w_s) begin
                    w_mr = 1'b1;
                    w_wb = 1'b1;
                end else begin
                    w_mw = 1'b1;
                end
            end
            2'b10: w_br = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_cond_pass = 1'b0;
        case (w_cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = ~w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = ~w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = ~w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = ~w_v;
            4'b1000: w_cond_pass = w_c & ~w_z;
            4'b1001: w_cond_pass = ~w_c | w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
            4'b1101: w_cond_pass = w_z | (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    assign w_store     = (w_mode == 2'b01) & ~w_s;
    assign two_src     = ~w_i | w_store;
    assign w_load_ctrl = ~flush & ~freeze & instr_valid & w_cond_pass;

    logic [3:0]  r_exe;
    logic        r_wb, r_mr, r_mw, r_br, r_sb, r_imm, r_valid;
    logic [3:0]  r_dest, r_src1;
    logic [11:0] r_shift;
    logic [23:0] r_simm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exe   <= 4'b0000;
            r_wb    <= 1'b0;
            r_mr    <= 1'b0;
            r_mw    <= 1'b0;
            r_br    <= 1'b0;
            r_sb    <= 1'b0;
            r_imm   <= 1'b0;
            r_valid <= 1'b0;
            r_dest  <= 4'h0;
            r_src1  <= 4'h0;
            r_shift <= 12'h000;
            r_simm  <= 24'h000000;
        end else begin
            // Operand fields always follow instr; only the controls are bubbled.
            r_imm   <= w_i;
            r_dest  <= instr[15:12];
            r_src1  <= instr[19:16];
            r_shift <= instr[11:0];
            r_simm  <= instr[23:0];
            if (w_load_ctrl) begin
                r_exe   <= w_exe;
                r_wb    <= w_wb;
                r_mr    <= w_mr;
                r_mw    <= w_mw;
                r_br    <= w_br;
                r_sb    <= w_sb;
                r_valid <= 1'b1;
            end else begin
                r_exe   <= 4'b0000;
                r_wb    <= 1'b0;
                r_mr    <= 1'b0;
                r_mw    <= 1'b0;
                r_br    <= 1'b0;
                r_sb    <= 1'b0;
                r_valid <= 1'b0;
            end
        end
    end

    assign exe_command   = r_exe;
    assign wb_en         = r_wb;
    assign mem_r_en      = r_mr;
    assign mem_w_en      = r_mw;
    assign branch        = r_br;
    assign s_bit         = r_sb;
    assign imm           = r_imm;
    assign valid_out     = r_valid;
    assign dest          = r_dest;
    assign src1          = r_src1;
    assign shift_operand = r_shift;
    assign signed_imm_24 = r_simm;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// tb/tb_id_ex_ctrl.sv - directed self-checking bench for id_ex_ctrl
module tb_id_ex_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        freeze;
    logic        flush;
    logic [3:0]  status;
    logic [3:0]  exe_command;
    logic        wb_en, mem_r_en, mem_w_en, branch, s_bit, imm, valid_out;
    logic [3:0]  dest, src1;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic        two_src;

    int checks = 0;
    int errors = 0;

    id_ex_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .freeze        (freeze),
        .flush         (flush),
        .status        (status),
        .exe_command   (exe_command),
        .wb_en         (wb_en),
        .mem_r_en      (mem_r_en),
        .mem_w_en      (mem_w_en),
        .branch        (branch),
        .s_bit         (s_bit),
        .imm           (imm),
        .valid_out     (valid_out),
        .dest          (dest),
        .src1          (src1),
        .shift_operand (shift_operand),
        .signed_imm_24 (signed_imm_24),
        .two_src       (two_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] i, input logic v, input logic fz,
                        input logic fl, input logic [3:0] st);
        @(negedge clk);
        instr       = i;
        instr_valid = v;
        freeze      = fz;
        flush       = fl;
        status      = st;
        @(posedge clk);
        #1;
    endtask

    // Controls in the order exe, wb, mr, mw, br, s, valid.
    task automatic ctrl(input string tag, input logic [3:0] e, input logic wb, input logic mr,
                        input logic mw, input logic br, input logic s, input logic v);
        check({tag, ".exe"},   exe_command, e);
        check({tag, ".wb"},    wb_en, wb);
        check({tag, ".mr"},    mem_r_en, mr);
        check({tag, ".mw"},    mem_w_en, mw);
        check({tag, ".br"},    branch, br);
        check({tag, ".s"},     s_bit, s);
        check({tag, ".valid"}, valid_out, v);
    endtask

    typedef struct { logic [3:0] op; logic s; logic [3:0] exe; logic wb; logic sb; logic v; } op_vec_t;
    typedef struct { logic [3:0] cond; logic [3:0] st; logic pass; } cond_vec_t;

    op_vec_t op_tab[16] = '{
        '{4'b1101, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1},
        '{4'b1111, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b1},
        '{4'b0100, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b1},
        '{4'b0101, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b1},
        '{4'b0010, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1},
        '{4'b0110, 1'b1, 4'b0101, 1'b1, 1'b1, 1'b1},
        '{4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b1},
        '{4'b1100, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b1},
        '{4'b0001, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1},
        '{4'b1010, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1},
        '{4'b1000, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b1},
        '{4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1},
        '{4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1},
        '{4'b1001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1},
        '{4'b1011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1},
        '{4'b1110, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1}
    };

    // status is {N,Z,C,V}
    cond_vec_t cond_tab[24] = '{
        '{4'h0, 4'b0100, 1'b1}, '{4'h0, 4'b1011, 1'b0},
        '{4'h1, 4'b0100, 1'b0}, '{4'h1, 4'b1011, 1'b1},
        '{4'h2, 4'b0010, 1'b1}, '{4'h2, 4'b1101, 1'b0},
        '{4'h3, 4'b0010, 1'b0},
        '{4'h4, 4'b1000, 1'b1}, '{4'h4, 4'b0111, 1'b0},
        '{4'h5, 4'b1000, 1'b0},
        '{4'h6, 4'b0001, 1'b1}, '{4'h6, 4'b1110, 1'b0},
        '{4'h7, 4'b0001, 1'b0},
        '{4'h8, 4'b0010, 1'b1}, '{4'h8, 4'b0110, 1'b0},
        '{4'h9, 4'b0010, 1'b0}, '{4'h9, 4'b0110, 1'b1},
        '{4'hA, 4'b1001, 1'b1}, '{4'hA, 4'b1000, 1'b0},
        '{4'hB, 4'b0001, 1'b1},
        '{4'hC, 4'b0000, 1'b1}, '{4'hC, 4'b0100, 1'b0},
        '{4'hD, 4'b0000, 1'b0}, '{4'hF, 4'b1111, 1'b0}
    };

    initial begin
        rst_n       = 1'b0;
        instr       = 32'hE2821005;
        instr_valid = 1'b1;
        freeze      = 1'b0;
        flush       = 1'b0;
        status      = 4'b0000;
        #3;
        ctrl("reset", 4'b0000, 0, 0, 0, 0, 0, 0);
        check("reset.dest", dest, 4'h0);
        check("reset.shift", shift_operand, 12'h000);
        check("reset.simm", signed_imm_24, 24'h0);
        check("reset.two_src_add", two_src, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(32'hE2821005, 1, 0, 0, 4'b0000);
        ctrl("add", 4'b0010, 1, 0, 0, 0, 0, 1);
        check("add.imm", imm, 1'b1);
        check("add.dest", dest, 4'h1);
        check("add.src1", src1, 4'h2);
        check("add.shift", shift_operand, 12'h005);

        step(32'hE1510002, 1, 0, 0, 4'b0000);
        ctrl("cmp", 4'b0100, 0, 0, 0, 0, 1, 1);
        check("cmp.src1", src1, 4'h1);
        check("cmp.two_src", two_src, 1'b1);

        step(32'hE4910004, 1, 0, 0, 4'b0000);
        ctrl("ldr", 4'b0010, 1, 1, 0, 0, 0, 1);
        step(32'hE4810004, 1, 0, 0, 4'b0000);
        ctrl("str", 4'b0010, 0, 0, 1, 0, 0, 1);
        check("str.two_src", two_src, 1'b1);
        step(32'hE6810004, 1, 0, 0, 4'b0000);
        check("str_imm.two_src", two_src, 1'b1);

        step(32'h02821005, 1, 0, 0, 4'b0000);
        ctrl("eq_fail", 4'b0000, 0, 0, 0, 0, 0, 0);
        check("eq_fail.dest", dest, 4'h1);
        step(32'h02821005, 1, 0, 0, 4'b0100);
        ctrl("eq_pass", 4'b0010, 1, 0, 0, 0, 0, 1);

        step(32'hEAFFFFFE, 1, 0, 1, 4'b0000);
        ctrl("b_flush", 4'b0000, 0, 0, 0, 0, 0, 0);
        check("b_flush.simm", signed_imm_24, 24'hFFFFFE);
        step(32'hEAFFFFFE, 1, 0, 0, 4'b0000);
        ctrl("b", 4'b0000, 0, 0, 0, 1, 0, 1);
        check("b.simm", signed_imm_24, 24'hFFFFFE);
        check("b.two_src", two_src, 1'b0);

        step(32'hE2821005, 1, 1, 0, 4'b0000);
        ctrl("freeze", 4'b0000, 0, 0, 0, 0, 0, 0);
        check("freeze.src1", src1, 4'h2);
        step(32'hE2821005, 1, 1, 1, 4'b0000);
        ctrl("frz_flush", 4'b0000, 0, 0, 0, 0, 0, 0);
        step(32'hE2821005, 0, 0, 0, 4'b0000);
        ctrl("invalid", 4'b0000, 0, 0, 0, 0, 0, 0);
        step(32'hE2821005, 1, 0, 0, 4'b0000);
        ctrl("resume", 4'b0010, 1, 0, 0, 0, 0, 1);

        step(32'hEC821005, 1, 0, 0, 4'b0000);
        ctrl("mode11", 4'b0000, 0, 0, 0, 0, 0, 1);

        for (int k = 0; k < 16; k++) begin
            step({4'hE, 2'b00, 1'b0, op_tab[k].op, op_tab[k].s, 4'h3, 4'h4, 12'h000}, 1, 0, 0, 4'b0000);
            ctrl($sformatf("op%0d", k), op_tab[k].exe, op_tab[k].wb, 0, 0, 0, op_tab[k].sb, op_tab[k].v);
        end

        for (int k = 0; k < 24; k++) begin
            step({cond_tab[k].cond, 28'h2821005}, 1, 0, 0, cond_tab[k].st);
            check($sformatf("cond%0d.valid", k), valid_out, cond_tab[k].pass);
            check($sformatf("cond%0d.wb", k), wb_en, cond_tab[k].pass);
        end

        step(32'hE2821005, 1, 0, 0, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        ctrl("async_rst", 4'b0000, 0, 0, 0, 0, 0, 0);
        check("async_rst.src1", src1, 4'h0);
        instr = 32'hE1510002;
        #1;
        check("rst.two_src", two_src, 1'b1);
        @(negedge clk);
        ctrl("rst_hold", 4'b0000, 0, 0, 0, 0, 0, 0);
        instr = 32'hE2821005;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ctrl("rst_release", 4'b0010, 1, 0, 0, 0, 0, 1);
        check("rst_release.dest", dest, 4'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl.md
ID_EX_CTRL -- requirements
Module: id_ex_ctrl

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 instr  in  32  instruction from IF/ID register.
REQ-005 instr_valid  in  1  instr holds a real instruction.
REQ-006 freeze  in  1  hazard stall; inject bubble this cycle.
REQ-007 flush  in  1  branch taken in EX; inject bubble this cycle.
REQ-008 status  in  4  flags {N,Z,C,V} from status register.
REQ-009 exe_command  out  4  ALU command to EX: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR.
REQ-010 wb_en, mem_r_en, mem_w_en, branch, s_bit, imm, valid_out  out  1 each  registered controls.
REQ-011 dest, src1  out  4 each  registered Rd, Rn.
REQ-012 shift_operand  out  12; signed_imm_24  out  24  registered operand fields.
REQ-013 two_src  out  1  combinational: (~instr[25]) | store; for hazard unit.

Function
REQ-014 Fields: cond=instr[31:28], mode=[27:26], I=[25], opcode=[24:21], S=[20], Rn=[19:16], Rd=[15:12], shift=[11:0], imm24=[23:0].
REQ-015 mode 00 decode: MOV 1101, MVN 1111, ADD 0100, ADC 0101, SUB 0010, SBC 0110, AND 0000, ORR 1100, EOR 0001 -> listed exe_command, wb_en=1, s_bit=S.
REQ-016 CMP 1010 -> 0100, TST 1000 -> 0110; both wb_en=0, s_bit=1 regardless of S.
REQ-017 mode 01: S=1 load (exe 0010, mem_r_en=1, wb_en=1); S=0 store (exe 0010, mem_w_en=1, wb_en=0); s_bit=0; opcode ignored.
REQ-018 mode 10: branch=1, exe 0000, wb_en=0, s_bit=0.
REQ-019 mode 11 or unlisted mode-00 opcode: all controls 0, exe 0000, valid_out=1 (NOP).
REQ-020 Condition pass: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
REQ-021 Bubble = exe_command, wb_en, mem_r_en, mem_w_en, branch, s_bit, valid_out all 0; dest/src1/operand fields still load from instr.
REQ-022 Edge load priority: flush > freeze > (instr_valid=0 or cond fail) -> bubble; else decoded controls, valid_out=1.
REQ-023 Latency exactly one cycle instr -> outputs; no hold state; a new value is captured every edge.
REQ-024 Condition uses status sampled same cycle as instr (no forwarding of in-flight S updates).
REQ-025 flush and freeze together -> single bubble, no other effect.

Reset
REQ-026 rst_n low asynchronously forces every registered output to 0 without waiting for clk.
REQ-027 Reset mid-stream discards the in-flight instruction; first edge after release loads normally.
REQ-028 two_src is combinational and tracks instr during reset.

Verification
REQ-029 instr=E2821005, valid, status 0 -> next edge: exe 0010, wb_en 1, imm 1, dest 1, src1 2, shift_operand 005, valid_out 1.
REQ-030 instr=E1510002 -> exe 0100, wb_en 0, s_bit 1, src1 1, two_src 1.
REQ-031 instr=E4910004 -> mem_r_en 1, wb_en 1, exe 0010; instr=E4810004 -> mem_w_en 1, wb_en 0, two_src 1.
REQ-032 instr=02821005 (EQ) with status Z=0 -> bubble; with Z=1 -> ADD decode as REQ-029.
REQ-033 instr=EAFFFFFE with flush=1 -> bubble; flush=0 -> branch 1, signed_imm_24 FFFFFE.
REQ-034 Drive ADD stream, assert rst_n low between edges -> outputs 0 immediately; release -> next edge decodes current instr.
